// File: rtl/core_mem_seq_pkg.sv
// core_mem_seq_pkg: opcodes, inst bit positions and FSM states shared by the memory sequencer
package core_mem_seq_pkg;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_XREAD = 2'd1;
  localparam logic [1:0] OP_WB = 2'd2;
  localparam logic [1:0] OP_PREAD = 2'd3;
  localparam int A_XMEM_LSB = 7;
  localparam int WEN_XMEM = 18;
  localparam int CEN_XMEM = 19;
  localparam int A_PMEM_LSB = 20;
  localparam int WEN_PMEM = 31;
  localparam int CEN_PMEM = 32;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_XREAD, S_WB, S_PREAD, S_FIN} state_t;
  function automatic state_t op_state(input logic [1:0] op);
    return op == OP_LOAD ? S_LOAD : op == OP_XREAD ? S_XREAD : op == OP_WB ? S_WB : S_PREAD;
  endfunction
endpackage

// File: rtl/core_mem_seq_addr_gen.sv
// core_mem_seq_addr_gen: latches base/len on load, counts i on step; outputs addr=(base+i) mod 2^addr_width, last (i+1==len), active (i<len)
module core_mem_seq_addr_gen #(
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [addr_width-1:0] cmd_base,
  input  logic [addr_width:0]   cmd_len,
  output logic [addr_width-1:0] addr,
  output logic                  last,
  output logic                  active
);
  logic [addr_width-1:0] base_q;
  logic [addr_width:0] len_q, i;
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
      len_q <= '0;
      i <= '0;
    end else if (load) begin
      base_q <= cmd_base;
      len_q <= cmd_len;
      i <= '0;
    end else if (step) begin
      i <= i + (addr_width+1)'(1);
    end
  end
  assign addr = base_q + i[addr_width-1:0];
  assign last = (i + (addr_width+1)'(1)) == len_q;
  assign active = i < len_q;
endmodule

// File: rtl/core_mem_sequencer.sv
// core_mem_sequencer: command FSM (LOAD/XREAD/WB/PREAD) driving registered inst/D_xmem/busy/done/err from cmd_*, in_*, ofifo_valid, ctrl_bits; CORE_MEM_SEQ_BOUNDS_CHECK_EN rejects base+len > 2^addr_width
module core_mem_sequencer
  import core_mem_seq_pkg::*;
#(
  parameter int bw = 4,
  parameter int row = 8,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [addr_width-1:0] cmd_base,
  input  logic [addr_width:0]   cmd_len,
  input  logic [7:0]            ctrl_bits,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [bw*row-1:0]     in_data,
  input  logic                  ofifo_valid,
  output logic [33:0]           inst,
  output logic [bw*row-1:0]     D_xmem,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  state_t state;
  logic [addr_width-1:0] addr;
  logic last, active, step, oob;
  logic [33:0] idle_inst;
`ifdef CORE_MEM_SEQ_BOUNDS_CHECK_EN
  logic [addr_width+1:0] span;
  assign span = (addr_width+2)'(cmd_base) + (addr_width+2)'(cmd_len);
  assign oob = span > ((addr_width+2)'(1) << addr_width);
`else
  assign oob = 1'b0;
`endif
  assign idle_inst = {ctrl_bits[7], 2'b11, {addr_width{1'b0}}, 2'b11, {addr_width{1'b0}}, ctrl_bits[6:0]};
  assign cmd_ready = state == S_IDLE;
  assign in_ready = state == S_LOAD && active;
  assign step = (in_ready && in_valid) || state == S_XREAD || state == S_PREAD || (state == S_WB && ofifo_valid);
  core_mem_seq_addr_gen #(.addr_width(addr_width)) u_addr_gen (
    .clk(clk),
    .reset(reset),
    .load(cmd_valid && cmd_ready),
    .step(step),
    .cmd_base(cmd_base),
    .cmd_len(cmd_len),
    .addr(addr),
    .last(last),
    .active(active)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      inst <= {1'b0, 2'b11, {addr_width{1'b0}}, 2'b11, {addr_width{1'b0}}, 7'd0};
      D_xmem <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      inst <= idle_inst;
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          busy <= 1'b1;
          err <= err | oob;
          state <= (oob || cmd_len == '0) ? S_FIN : op_state(cmd_op);
        end
        S_LOAD: if (in_valid) begin
          inst[CEN_XMEM] <= 1'b0;
          inst[WEN_XMEM] <= 1'b0;
          inst[A_XMEM_LSB +: addr_width] <= addr;
          D_xmem <= in_data;
          if (last) state <= S_FIN;
        end
        S_XREAD: begin
          inst[CEN_XMEM] <= 1'b0;
          inst[A_XMEM_LSB +: addr_width] <= addr;
          if (last) state <= S_FIN;
        end
        S_WB: if (ofifo_valid) begin
          inst[CEN_PMEM] <= 1'b0;
          inst[WEN_PMEM] <= 1'b0;
          inst[A_PMEM_LSB +: addr_width] <= addr;
          if (last) state <= S_FIN;
        end
        S_PREAD: begin
          inst[CEN_PMEM] <= 1'b0;
          inst[A_PMEM_LSB +: addr_width] <= addr;
          if (last) state <= S_FIN;
        end
        default: begin
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_core_mem_sequencer.sv
// tb_core_mem_sequencer: randomized self-checking bench for core_mem_sequencer against a per-command access model
module tb_core_mem_sequencer;
  logic clk = 0, reset = 1, cmd_valid = 0, cmd_ready, in_valid = 0, in_ready, ofifo_valid = 0;
  logic busy, done, err;
  logic [1:0] cmd_op = 0;
  logic [10:0] cmd_base = 0;
  logic [11:0] cmd_len = 0;
  logic [7:0] ctrl_bits = 0;
  logic [31:0] in_data = 0, D_xmem;
  logic [33:0] inst;
  int checks = 0, passes = 0;
  logic exp_err = 0;
  always #5 clk = ~clk;
  core_mem_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .ctrl_bits(ctrl_bits), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .ofifo_valid(ofifo_valid), .inst(inst),
    .D_xmem(D_xmem), .busy(busy), .done(done), .err(err)
  );
  function automatic logic [33:0] exp_inst(input logic [1:0] op, input logic acc, input int a, input logic [7:0] c);
    logic [33:0] r;
    logic [10:0] aa;
    aa = a[10:0];
    r = '0;
    r[33] = c[7];
    r[6:0] = c[6:0];
    r[32] = 1; r[31] = 1; r[19] = 1; r[18] = 1;
    if (acc) begin
      if (op < 2) begin
        r[19] = 0; r[18] = (op == 1); r[17:7] = aa;
      end else begin
        r[32] = 0; r[31] = (op == 3); r[30:20] = aa;
      end
    end
    return r;
  endfunction
  task automatic run_cmd(input logic [1:0] op, input int base, input int len, input logic [31:0] vpat, input logic [7:0] ctrl);
    int k, t, eff;
    logic v, oob, acc;
    logic [31:0] d;
    oob = 0;
`ifdef CORE_MEM_SEQ_BOUNDS_CHECK_EN
    oob = (base + len) > 2048;
`endif
    eff = oob ? 0 : len;
    exp_err = exp_err | oob;
    ctrl_bits = ctrl; cmd_op = op; cmd_base = base[10:0]; cmd_len = len[11:0]; cmd_valid = 1;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle got %b exp 1", cmd_ready); else passes++;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_base = 11'($urandom); cmd_len = 12'($urandom);
    checks++; if (busy !== 1'b1) $display("FAIL busy_start got %b exp 1", busy); else passes++;
    checks++; if (inst !== exp_inst(op, 0, 0, ctrl)) $display("FAIL inst_accept got %h exp %h", inst, exp_inst(op, 0, 0, ctrl)); else passes++;
    k = 0; t = 0;
    while (k < eff) begin
      v = vpat[t % 32] | (t >= 32);
      d = $urandom;
      in_data = d;
      in_valid = (op == 0) ? v : 1'($urandom);
      ofifo_valid = (op == 2) ? v : 1'($urandom);
      checks++; if (in_ready !== (op == 0)) $display("FAIL in_ready op=%0d k=%0d got %b exp %b", op, k, in_ready, op == 0); else passes++;
      checks++; if (cmd_ready !== 1'b0) $display("FAIL cmd_ready_busy k=%0d got %b exp 0", k, cmd_ready); else passes++;
      @(posedge clk); #1;
      acc = (op == 1) || (op == 3) || v;
      checks++; if (inst !== exp_inst(op, acc, (base + k) % 2048, ctrl)) $display("FAIL inst op=%0d base=%0d k=%0d got %h exp %h", op, base, k, inst, exp_inst(op, acc, (base + k) % 2048, ctrl)); else passes++;
      if (op == 0 && acc) begin
        checks++; if (D_xmem !== d) $display("FAIL D_xmem k=%0d got %h exp %h", k, D_xmem, d); else passes++;
      end
      checks++; if (done !== 1'b0) $display("FAIL done_early k=%0d got %b exp 0", k, done); else passes++;
      if (acc) k++;
      t++;
    end
    in_valid = 0; ofifo_valid = 0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1) $display("FAIL done_pulse op=%0d len=%0d got %b exp 1", op, len, done); else passes++;
    checks++; if (inst !== exp_inst(op, 0, 0, ctrl)) $display("FAIL inst_fin got %h exp %h", inst, exp_inst(op, 0, 0, ctrl)); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_end got %b exp 0", busy); else passes++;
    checks++; if (err !== exp_err) $display("FAIL err got %b exp %b", err, exp_err); else passes++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL done_width got %b exp 0", done); else passes++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_after got %b exp 1", cmd_ready); else passes++;
  endtask
  task automatic test_reset;
    reset = 1; ctrl_bits = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (inst !== exp_inst(0, 0, 0, 8'h00)) $display("FAIL reset_inst got %h exp %h", inst, exp_inst(0, 0, 0, 8'h00)); else passes++;
    checks++; if ({D_xmem, busy, done, err, in_ready} !== 36'd0) $display("FAIL reset_outs got %h exp 0", {D_xmem, busy, done, err, in_ready}); else passes++;
    reset = 0; exp_err = 0;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); else passes++;
  endtask
  task automatic test_load;
    run_cmd(0, 5, 3, 32'b1101, 8'h00);
  endtask
  task automatic test_xread_wrap;
    run_cmd(1, 2046, 4, 32'h0, 8'h3C);
  endtask
  task automatic test_wb;
    run_cmd(2, 0, 2, 32'h88, 8'h12);
  endtask
  task automatic test_pread_zero;
    run_cmd(3, 77, 0, 32'h0, 8'h55);
  endtask
  task automatic test_ctrl;
    run_cmd(0, int'($urandom_range(0, 2000)), 5, $urandom, 8'h81);
  endtask
  task automatic test_full_len;
    run_cmd(1, 0, 2048, 32'h0, 8'h07);
  endtask
  task automatic test_reset_mid;
    logic [7:0] c;
    c = 8'($urandom);
    ctrl_bits = c; cmd_op = 1; cmd_base = 11'd100; cmd_len = 12'd8; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++; if (inst !== exp_inst(1, 1, 100 + k, c)) $display("FAIL mid_read k=%0d got %h exp %h", k, inst, exp_inst(1, 1, 100 + k, c)); else passes++;
    end
    reset = 1;
    @(posedge clk); #1;
    reset = 0; exp_err = 0;
    checks++; if (inst !== exp_inst(0, 0, 0, 8'h00)) $display("FAIL mid_reset_inst got %h exp %h", inst, exp_inst(0, 0, 0, 8'h00)); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset_busy got %b exp 0", busy); else passes++;
    for (int k = 0; k < 10; k++) begin
      checks++; if (done !== 1'b0) $display("FAIL mid_reset_done k=%0d got %b exp 0", k, done); else passes++;
      @(posedge clk); #1;
    end
    checks++; if (cmd_ready !== 1'b1) $display("FAIL mid_reset_ready got %b exp 1", cmd_ready); else passes++;
    run_cmd(3, 10, 3, 32'h0, c);
  endtask
  task automatic test_random;
    int base;
    for (int n = 0; n < 24; n++) begin
      base = ($urandom % 2) ? int'($urandom_range(2036, 2047)) : int'($urandom_range(0, 2047));
      run_cmd(2'($urandom), base, int'($urandom_range(0, 12)), $urandom, 8'($urandom));
    end
  endtask
  initial begin
    #1;
    test_reset;
    test_load;
    test_xread_wrap;
    test_wb;
    test_pread_zero;
    test_ctrl;
    test_reset_mid;
    test_full_len;
    test_random;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
